lfsr_rand_gen: RTL and testbench
================================

// Module: lfsr_rand_gen
// PURPOSE
//  Parametrised Fibonacci-LFSR random source for the game logic (obstacle spawn, gap timing).
//  Free-running raw state plus an on-request bounded draw: req/bound in, value in [0,bound) out
//  with a valid pulse. Adds seed loading, lock-up recovery and rejection sampling with a
//  guaranteed-latency fallback.
// PARAMETERS
//  WIDTH     30             LFSR state width (>=4)
//  TAPS      30'h20000029   feedback mask; bit i set => state[i] XORed into feedback
//  SEED      30'h20000029   reset/fallback seed, must be nonzero
//  OUT_W     8              width of bound/value
//  MAX_TRIES 8              rejection attempts before fallback (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  en        in   1      advance LFSR one step this cycle (free-run enable)
//  seed_we   in   1      load seed_din into LFSR
//  seed_din  in   WIDTH  new seed
//  req       in   1      start a bounded draw (sampled only when busy=0)
//  bound     in   OUT_W  exclusive upper limit, sampled with req
//  busy      out  1      draw in progress
//  valid     out  1      one-cycle pulse: value holds a fresh result
//  value     out  OUT_W  bounded result, held until next valid
//  fallback  out  1      qualifies valid: result came from fallback path
//  raw       out  WIDTH  current LFSR state
// BEHAVIOUR
//  Reset: state=SEED, FSM=IDLE, busy=0, valid=0, value=0, fallback=0, tries=0.
//  Step: next = {s[WIDTH-2:0], ^(s & TAPS)}.
//  State update priority per cycle: seed_we > (en | FSM==DRAW) step > hold.
//  seed_we with seed_din==0 loads SEED instead; if s==0 is ever seen, next state = SEED.
//  FSM IDLE: req=1 -> latch bound, tries=0, busy=1, go DRAW. req while busy ignored.
//   IDLE with req and bound==0: go DRAW anyway; first DRAW cycle returns value=0, valid=1.
//  FSM DRAW (one attempt per cycle, LFSR steps every DRAW cycle even if en=0):
//   mask = all ones up to MSB of (bound-1) (bound==1 -> mask=0); cand = s[OUT_W-1:0] & mask.
//   cand < bound -> value<=cand, valid=1, fallback=0, go IDLE.
//   else tries==MAX_TRIES-1 -> value<=cand-bound (cand<2*bound, so in range), valid=1,
//   fallback=1, go IDLE; else tries++ and stay.
//  Latency: req at cycle N -> DRAW from N+1 -> valid at N+2 (best), N+1+MAX_TRIES (worst).
//  valid registered, high exactly one cycle; busy drops in the same cycle valid rises.
//  seed_we during DRAW: seed loaded, draw continues from new state, tries not reset.
//  bound captured at req; later changes on bound ignored until next draw.
//  rst mid-draw: FSM to IDLE immediately, no valid pulse, pending draw discarded.
//  All arithmetic unsigned OUT_W bits; no wrap possible in fallback subtraction.
// STRUCTURE
//  rand_defs.vh: default TAPS/SEED constants for widths 16/30/32, FSM state encodings.
//  Sub-module lfsr_core (WIDTH, TAPS, SEED): state reg, step, seed load, lock-up recovery;
//  top holds the draw FSM, mask generator, tries counter and output regs.
// TESTING
//  Step: rst then en=1 for 3 cycles -> raw 0x20000029 -> 0x00000052 -> 0x000000A4 -> 0x00000149.
//  Draw: en=0, req=1 bound=100 after rst -> mask 0x7F, cand 41, valid at N+2, value=41,
//   fallback=0.
//  Fallback: seed forcing MAX_TRIES rejections (bound=65, low bits >=65 each step) ->
//   valid at N+1+MAX_TRIES, fallback=1, value<65.
//  Seed: seed_we=1 seed_din=0 -> raw=SEED; seed_din=0x1 -> raw=0x1; seed_we+en same cycle -> load wins.
//  Edge: bound=0 -> value=0; bound=1 -> value=0 first attempt; req during busy -> ignored.
//  Reset: assert rst in DRAW -> busy=0, valid never pulses, raw=SEED; random bounds 1..255 x1000
//   -> value<bound.

Source files
------------

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared constants for the LFSR random source: default tap masks and seeds
// for the supported state widths, plus the draw FSM state encoding.
package lfsr_rand_gen_pkg;

    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [15:0] SEED_16 = 16'hACE1;
    localparam logic [29:0] TAPS_30 = 30'h20000029;
    localparam logic [29:0] SEED_30 = 30'h20000029;
    localparam logic [31:0] TAPS_32 = 32'h80200003;
    localparam logic [31:0] SEED_32 = 32'h00000001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } draw_state_e;

    // Default feedback mask for a given state width (30-bit set otherwise).
    function automatic logic [31:0] default_taps(input int w);
        case (w)
            16:      return 32'(TAPS_16);
            32:      return TAPS_32;
            default: return 32'(TAPS_30);
        endcase
    endfunction

    // Default nonzero seed for a given state width (30-bit set otherwise).
    function automatic logic [31:0] default_seed(input int w);
        case (w)
            16:      return 32'(SEED_16);
            32:      return SEED_32;
            default: return 32'(SEED_30);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_lfsr_core.sv
// Fibonacci LFSR state register with seed loading and lock-up recovery.
// A zero seed is replaced by SEED, and an all-zero state (which would
// otherwise stick forever) is pulled back to SEED on the next cycle.
module lfsr_core #(
    parameter int               WIDTH = 30,
    parameter logic [WIDTH-1:0] TAPS  = 30'h20000029,
    parameter logic [WIDTH-1:0] SEED  = 30'h20000029
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Next state: seed load beats lock-up recovery beats a step beats hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (load_val_i == '0) ? SEED : load_val_i;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    // State register, reset to the configured seed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Random source for game logic: free-running LFSR state on raw, plus a
// bounded draw that returns a value in [0,bound). Each draw cycle masks the
// low LFSR bits to the smallest power-of-two span covering bound and rejects
// out-of-range candidates; after MAX_TRIES rejections the last candidate is
// folded into range by subtracting bound, so latency is strictly bounded.
module lfsr_rand_gen
    import lfsr_rand_gen_pkg::*;
#(
    parameter int               WIDTH     = 30,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(default_seed(WIDTH)),
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_din,
    input  logic             req,
    input  logic [OUT_W-1:0] bound,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic             fallback,
    output logic [WIDTH-1:0] raw
);

    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    draw_state_e      state_q, state_d;
    logic [OUT_W-1:0] bound_q, bound_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             fallback_q, fallback_d;
    logic [OUT_W-1:0] cand;

    // All ones up to the MSB of (b-1); b==1 yields zero.
    function automatic logic [OUT_W-1:0] span_mask(input logic [OUT_W-1:0] b);
        logic [OUT_W-1:0] m;
        m = b - OUT_W'(1);
        for (int i = 1; i < OUT_W; i++) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    // The LFSR advances on the free-run enable and on every draw attempt.
    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i      (clk),
        .rst_i      (rst),
        .step_i     (en | (state_q == ST_DRAW)),
        .load_i     (seed_we),
        .load_val_i (seed_din),
        .state_o    (raw)
    );

    // Draw FSM: accept a request in IDLE, make one attempt per DRAW cycle.
    always_comb begin
        state_d    = state_q;
        bound_d    = bound_q;
        tries_d    = tries_q;
        valid_d    = 1'b0;
        value_d    = value_q;
        fallback_d = fallback_q;
        cand       = raw[OUT_W-1:0] & span_mask(bound_q);
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    bound_d = bound;
                    tries_d = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (bound_q == '0) begin
                    // Empty range: return zero rather than spin.
                    value_d    = '0;
                    valid_d    = 1'b1;
                    fallback_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (cand < bound_q) begin
                    value_d    = cand;
                    valid_d    = 1'b1;
                    fallback_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (tries_q == LAST_TRY) begin
                    // cand < 2*bound here, so the difference cannot wrap.
                    value_d    = cand - bound_q;
                    valid_d    = 1'b1;
                    fallback_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, draw context and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bound_q    <= '0;
            tries_q    <= '0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bound_q    <= bound_d;
            tries_q    <= tries_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            fallback_q <= fallback_d;
        end
    end

    assign busy     = (state_q == ST_DRAW);
    assign valid    = valid_q;
    assign value    = value_q;
    assign fallback = fallback_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: a cycle-level behavioural model checked against
// every DUT output each cycle, directed scenarios with literal expectations,
// and a randomized phase of at least 1000 bounded draws.
module tb_lfsr_rand_gen;

    localparam int          W         = 30;
    localparam int          OW        = 8;
    localparam int          MAX_TRIES = 8;
    localparam logic [29:0] M_TAPS    = 30'h20000029;
    localparam logic [29:0] M_SEED    = 30'h20000029;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          seed_we = 1'b0;
    logic [W-1:0]  seed_din = '0;
    logic          req = 1'b0;
    logic [OW-1:0] bound = '0;
    logic          busy;
    logic          valid;
    logic [OW-1:0] value;
    logic          fallback;
    logic [W-1:0]  raw;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [29:0] m_s     = M_SEED;
    bit          m_draw  = 1'b0;
    int          m_bound = 0;
    int          m_tries = 0;
    bit          m_valid = 1'b0;
    int          m_value = 0;
    bit          m_fb    = 1'b0;

    lfsr_rand_gen #(
        .WIDTH     (W),
        .TAPS      (M_TAPS),
        .SEED      (M_SEED),
        .OUT_W     (OW),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .seed_we  (seed_we),
        .seed_din (seed_din),
        .req      (req),
        .bound    (bound),
        .busy     (busy),
        .valid    (valid),
        .value    (value),
        .fallback (fallback),
        .raw      (raw)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // One LFSR step: double the state modulo 2^30 and append the tap parity.
    function automatic logic [29:0] lstep(input logic [29:0] s);
        longint unsigned v;
        longint unsigned par;
        if (s == 0) return M_SEED;
        par = longint'($countones(s & M_TAPS)) % 2;
        v = (longint'(s) * 2 + par) % (64'd1 << 30);
        return 30'(v);
    endfunction

    // Smallest power of two that is >= b.
    function automatic int span(input int b);
        int p = 1;
        while (p < b) p = p * 2;
        return p;
    endfunction

    task automatic model_reset();
        m_s = M_SEED; m_draw = 0; m_bound = 0; m_tries = 0;
        m_valid = 0; m_value = 0; m_fb = 0;
    endtask

    task automatic model_step();
        bit adv;
        int cand;
        adv = en | m_draw;
        m_valid = 0;
        if (m_draw) begin
            cand = int'(m_s % 256) % span(m_bound);
            if (m_bound == 0) begin
                m_valid = 1; m_value = 0; m_fb = 0; m_draw = 0;
            end else if (cand < m_bound) begin
                m_valid = 1; m_value = cand; m_fb = 0; m_draw = 0;
            end else if (m_tries == MAX_TRIES - 1) begin
                m_valid = 1; m_value = cand - m_bound; m_fb = 1; m_draw = 0;
            end else begin
                m_tries++;
            end
        end else if (req) begin
            m_draw = 1; m_bound = int'(bound); m_tries = 0;
        end
        if (seed_we)  m_s = (seed_din == 0) ? M_SEED : seed_din;
        else if (adv) m_s = lstep(m_s);
        else if (m_s == 0) m_s = M_SEED;
    endtask

    // Model update on each active edge, then compare every output.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            chk("raw", raw, m_s);
            chk("busy", busy, m_draw);
            chk("valid", valid, m_valid);
            chk("value", value, m_value);
            chk("fallback", fallback, m_fb);
            if (m_valid && m_bound != 0) chk("value_lt_bound", value < m_bound, 1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue a request at a falling edge and wait for valid; lat counts
    // rising edges from the one that samples req up to the valid edge.
    task automatic draw(input int b, input bit poke, output int lat,
                        output int v, output bit fb);
        bit ok = 0;
        req = 1'b1;
        bound = OW'(b);
        lat = 0; v = 0; fb = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            req = (poke && lat == 2);
            if (poke && lat == 2) bound = 8'd3;
            if (valid) begin
                ok = 1; v = int'(value); fb = fallback;
                break;
            end
        end
        req = 1'b0;
        if (!ok) chk("draw_timeout", valid, 1);
    endtask

    function automatic bit rejects_all(input logic [29:0] s);
        for (int k = 0; k < MAX_TRIES; k++) begin
            if ((s % 128) < 65) return 0;
            s = lstep(s);
        end
        return 1;
    endfunction

    logic [29:0] fb_seed;

    initial begin
        int lat, v, nv;
        bit fb, found;
        logic [29:0] step_exp [3];
        step_exp[0] = 30'h00000052;
        step_exp[1] = 30'h000000A4;
        step_exp[2] = 30'h00000149;

        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Reset state against literals
        chk("rst_raw", raw, 30'h20000029);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_value", value, 0);
        chk("rst_fallback", fallback, 0);
        chk("model_seed", m_s, 30'h20000029);

        // Free-running steps
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("step_raw", raw, step_exp[i]);
            chk("model_step", m_s, step_exp[i]);
        end
        en = 1'b0;

        // First draw from reset seed: low byte 0x29 = 41 under mask 0x7F
        do_reset();
        draw(100, 0, lat, v, fb);
        chk("draw_lat", lat, 2);
        chk("draw_value", v, 41);
        chk("draw_model_value", m_value, 41);
        chk("draw_fb", fb, 0);

        // Seed loading
        seed_we = 1'b1; seed_din = '0;
        @(posedge clk); @(negedge clk);
        chk("seed_zero", raw, 30'h20000029);
        seed_din = 30'h1;
        @(posedge clk); @(negedge clk);
        chk("seed_one", raw, 30'h1);
        seed_din = 30'h1234; en = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("seed_beats_en", raw, 30'h1234);
        seed_we = 1'b0; en = 1'b0;

        // Find a seed whose first MAX_TRIES states all reject for bound=65
        found = 0;
        fb_seed = 30'h1;
        for (int i = 0; i < 5000 && !found; i++) begin
            fb_seed = 30'($urandom) | 30'h1;
            found = rejects_all(fb_seed);
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL fb_seed_search: got none required a rejecting seed");
        end

        // Fallback draw, with a req/bound change poked in while busy
        seed_we = 1'b1; seed_din = fb_seed;
        @(posedge clk); @(negedge clk);
        seed_we = 1'b0;
        draw(65, 1, lat, v, fb);
        chk("fb_lat", lat, 1 + MAX_TRIES);
        chk("fb_flag", fb, 1);
        chk("fb_range", v < 65, 1);
        @(posedge clk); @(negedge clk);
        chk("busy_req_ignored", busy, 0);

        // Edge bounds
        draw(0, 0, lat, v, fb);
        chk("b0_lat", lat, 2);
        chk("b0_value", v, 0);
        draw(1, 0, lat, v, fb);
        chk("b1_lat", lat, 2);
        chk("b1_value", v, 0);
        chk("b1_fb", fb, 0);

        // Reset in the middle of a long draw
        seed_we = 1'b1; seed_din = fb_seed;
        @(posedge clk); @(negedge clk);
        seed_we = 1'b0;
        req = 1'b1; bound = 8'd65;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_raw", raw, 30'h20000029);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_no_valid", valid, 0);
            chk("rst_raw_held", raw, 30'h20000029);
        end

        // Randomized traffic until 1000 draws have completed
        nv = 0;
        for (int c = 0; c < 20000 && nv < 1000; c++) begin
            @(negedge clk);
            if (valid) nv++;
            en       = 1'($urandom % 2);
            seed_we  = (($urandom % 64) == 0);
            seed_din = (($urandom % 4) == 0) ? 30'h0 : 30'($urandom);
            req      = 1'($urandom % 2);
            bound    = 8'($urandom_range(1, 255));
        end
        chk("rand_draw_count", nv >= 1000, 1);
        en = 0; seed_we = 0; req = 0;
        @(posedge clk); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
